// File: rtl/weight_feed_ctrl.sv
// Weight-feed sequencer: per tile FETCH (1) -> LOAD (1) -> 4 SHIFT beats, so 6 cycles per tile at full rate.
// Backpressure: pe_ready=0 stalls SHIFT in place; abort drops the job on the next edge with no done pulse.
module weight_feed_ctrl #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_tiles,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              pe_ready,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    output logic              en_in,
    output logic              en_out,
    output logic              wvalid,
    output logic [1:0]        beat_idx,
    output logic [CNT_W-1:0]  tile_idx
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_SHIFT = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   num_r, num_nxt;
    logic [ADDR_W-1:0]  base_r, base_nxt;
    logic [CNT_W-1:0]   tile_nxt;
    logic [1:0]         beat_cnt, beat_nxt;
    logic [CNT_W:0]     tile_inc;

    // One extra bit so num_tiles = 2^CNT_W-1 finishes instead of wrapping.
    assign tile_inc = {1'b0, tile_idx} + 1'b1;

    always_comb begin
        state_nxt   = state;
        num_nxt     = num_r;
        base_nxt    = base_r;
        tile_nxt    = tile_idx;
        beat_nxt    = beat_cnt;
        busy        = (state != S_IDLE);
        done        = (state == S_DONE) && !abort;
        mem_rd_en   = (state == S_FETCH);
        mem_rd_addr = mem_rd_en ? (base_r + ADDR_W'(tile_idx)) : '0;
        en_in       = (state == S_LOAD);
        en_out      = (state == S_SHIFT) && pe_ready && !abort;

        case (state)
            S_IDLE: begin
                if (start && !abort) begin
                    num_nxt   = num_tiles;
                    base_nxt  = base_addr;
                    tile_nxt  = '0;
                    state_nxt = (num_tiles == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: state_nxt = S_LOAD;
            S_LOAD: begin
                beat_nxt  = 2'd0;
                state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                if (en_out) begin
                    beat_nxt = beat_cnt + 2'd1;
                    if (beat_cnt == 2'd3) begin
                        if (tile_inc < {1'b0, num_r}) begin
                            tile_nxt  = tile_inc[CNT_W-1:0];
                            state_nxt = S_FETCH;
                        end else begin
                            state_nxt = S_DONE;
                        end
                    end
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        if (abort && (state != S_IDLE)) begin
            state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            num_r    <= '0;
            base_r   <= '0;
            tile_idx <= '0;
            beat_cnt <= 2'd0;
            wvalid   <= 1'b0;
            beat_idx <= 2'd0;
        end else begin
            state    <= state_nxt;
            num_r    <= num_nxt;
            base_r   <= base_nxt;
            tile_idx <= tile_nxt;
            beat_cnt <= beat_nxt;
            wvalid   <= en_out;
            if (en_out) begin
                beat_idx <= beat_cnt;
            end
        end
    end

endmodule

// File: tb/tb_weight_feed_ctrl.sv
// Bench for weight_feed_ctrl: queue-of-steps reference model checked every cycle, plus directed scenarios.
module tb_weight_feed_ctrl;

    localparam int ADDR_W = 10;
    localparam int CNT_W  = 8;
    localparam int AMASK  = (1 << ADDR_W) - 1;
    localparam int K_FETCH = 0, K_LOAD = 1, K_SHIFT = 2, K_DONE = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [CNT_W-1:0]  num_tiles = '0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic              pe_ready = 1'b0;
    logic              abort = 1'b0;
    logic              busy, done, mem_rd_en, en_in, en_out, wvalid;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic [1:0]        beat_idx;
    logic [CNT_W-1:0]  tile_idx;

    always #5 clk = ~clk;

    weight_feed_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .num_tiles(num_tiles),
        .base_addr(base_addr), .pe_ready(pe_ready), .abort(abort),
        .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .en_in(en_in), .en_out(en_out), .wvalid(wvalid), .beat_idx(beat_idx),
        .tile_idx(tile_idx)
    );

    int vectors = 0;
    int errors  = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: a job is a list of steps; one step retires per cycle,
    // a SHIFT step only when pe_ready is high. Empty list means idle.
    typedef struct {
        int kind;
        int addr;
        int tile;
        int beat;
    } step_t;

    step_t q[$];
    int    exp_wv = 0;
    int    exp_bi = 0;
    int    last_tile = 0;
    bit    m_eo;

    function automatic void build(input int n, input int b);
        last_tile = 0;
        if (n == 0) begin
            q.push_back('{K_DONE, 0, 0, 0});
        end else begin
            for (int t = 0; t < n; t++) begin
                q.push_back('{K_FETCH, (b + t) & AMASK, t, 0});
                q.push_back('{K_LOAD, 0, t, 0});
                for (int bt = 0; bt < 4; bt++) q.push_back('{K_SHIFT, 0, t, bt});
            end
            q.push_back('{K_DONE, 0, n - 1, 0});
        end
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            exp_wv    = 0;
            exp_bi    = 0;
            last_tile = 0;
        end else begin
            m_eo   = (q.size() > 0) && (q[0].kind == K_SHIFT) && pe_ready && !abort;
            exp_wv = int'(m_eo);
            if (m_eo) exp_bi = q[0].beat;
            if (q.size() == 0) begin
                if (start && !abort) build(int'(num_tiles), int'(base_addr));
            end else if (abort) begin
                last_tile = q[0].tile;
                q.delete();
            end else if (q[0].kind != K_SHIFT || pe_ready) begin
                last_tile = q[0].tile;
                q.delete(0);
            end
        end
    end

    // Event logs of what the DUT actually did, for the directed scenarios.
    int cyc = 0;
    int rd_cyc[$], rd_addr[$], enin_cyc[$], eo_cyc[$], wv_cyc[$], wv_beat[$], done_cyc[$];
    int bad_eo = 0;
    int c_kind;

    always @(negedge clk) begin
        c_kind = (q.size() > 0) ? q[0].kind : -1;
        check("busy", int'(busy), int'(q.size() > 0));
        check("done", int'(done), int'(c_kind == K_DONE && !abort));
        check("mem_rd_en", int'(mem_rd_en), int'(c_kind == K_FETCH));
        check("mem_rd_addr", int'(mem_rd_addr), (c_kind == K_FETCH) ? q[0].addr : 0);
        check("en_in", int'(en_in), int'(c_kind == K_LOAD));
        check("en_out", int'(en_out), int'(c_kind == K_SHIFT && pe_ready && !abort));
        check("tile_idx", int'(tile_idx), (q.size() > 0) ? q[0].tile : last_tile);
        check("wvalid", int'(wvalid), exp_wv);
        if (exp_wv != 0) check("beat_idx", int'(beat_idx), exp_bi);
        if (rst) check("beat_idx_rst", int'(beat_idx), 0);
        if (mem_rd_en) begin
            rd_cyc.push_back(cyc);
            rd_addr.push_back(int'(mem_rd_addr));
        end
        if (en_in) enin_cyc.push_back(cyc);
        if (en_out) eo_cyc.push_back(cyc);
        if (en_out && !pe_ready) bad_eo++;
        if (wvalid) begin
            wv_cyc.push_back(cyc);
            wv_beat.push_back(int'(beat_idx));
        end
        if (done) done_cyc.push_back(cyc);
        cyc++;
    end

    function automatic int qat(input int qq[$], input int i);
        if (i < qq.size()) return qq[i];
        return -1;
    endfunction

    task automatic clear_logs();
        rd_cyc.delete(); rd_addr.delete(); enin_cyc.delete(); eo_cyc.delete();
        wv_cyc.delete(); wv_beat.delete(); done_cyc.delete();
        bad_eo = 0;
    endtask

    task automatic drive(input bit s, input int n, input int b, input bit pr, input bit ab);
        @(posedge clk);
        #2;
        start     = s;
        num_tiles = CNT_W'(n);
        base_addr = ADDR_W'(b);
        pe_ready  = pr;
        abort     = ab;
    endtask

    task automatic wait_idle(input int budget);
        int i;
        i = 0;
        while (busy === 1'b1 && i < budget) begin
            drive(0, 0, 0, 1, 0);
            i++;
        end
        check("wait_idle_timeout", int'(busy), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int s0;
    bit pat[7];

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_wvalid", int'(wvalid), 0);
        check("rst_addr", int'(mem_rd_addr), 0);
        check("rst_tile", int'(tile_idx), 0);
        @(posedge clk);
        #2 rst = 1'b0;
        drive(0, 0, 0, 1, 0);

        // Single tile at full rate: exact cycle timeline
        clear_logs();
        drive(1, 1, 'h010, 1, 0);
        s0 = cyc;
        drive(0, 0, 0, 1, 0);
        wait_idle(50);
        check("t1_rd_cnt", rd_cyc.size(), 1);
        check("t1_rd_cyc", qat(rd_cyc, 0) - s0, 1);
        check("t1_rd_addr", qat(rd_addr, 0), 'h010);
        check("t1_enin_cyc", qat(enin_cyc, 0) - s0, 2);
        check("t1_eo_cnt", eo_cyc.size(), 4);
        check("t1_eo_first", qat(eo_cyc, 0) - s0, 3);
        check("t1_eo_last", qat(eo_cyc, 3) - s0, 6);
        check("t1_wv_first", qat(wv_cyc, 0) - s0, 4);
        check("t1_wv_last", qat(wv_cyc, 3) - s0, 7);
        for (int i = 0; i < 4; i++) check("t1_beat", qat(wv_beat, i), i);
        check("t1_done_cnt", done_cyc.size(), 1);
        check("t1_done_cyc", qat(done_cyc, 0) - s0, 7);

        // Address wrap across the top of the buffer
        clear_logs();
        drive(1, 3, 'h3FF, 1, 0);
        drive(0, 0, 0, 1, 0);
        wait_idle(100);
        check("wrap_rd0", qat(rd_addr, 0), 'h3FF);
        check("wrap_rd1", qat(rd_addr, 1), 'h000);
        check("wrap_rd2", qat(rd_addr, 2), 'h001);
        check("wrap_wv_cnt", wv_cyc.size(), 12);
        check("wrap_done_cnt", done_cyc.size(), 1);

        // Stalls from pe_ready
        clear_logs();
        pat = '{1, 0, 0, 1, 1, 0, 1};
        drive(1, 1, 'h055, 1, 0);
        s0 = cyc;
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 0);
        for (int i = 0; i < 7; i++) drive(0, 0, 0, pat[i], 0);
        wait_idle(50);
        check("stall_eo_cnt", eo_cyc.size(), 4);
        check("stall_eo_bad", bad_eo, 0);
        check("stall_eo_c1", qat(eo_cyc, 1) - s0, 6);
        check("stall_eo_c3", qat(eo_cyc, 3) - s0, 9);
        for (int i = 0; i < 4; i++) check("stall_beat", qat(wv_beat, i), i);

        // Zero-tile job
        clear_logs();
        drive(1, 0, 'h123, 1, 0);
        s0 = cyc;
        drive(0, 0, 0, 1, 0);
        wait_idle(20);
        check("zero_done_cnt", done_cyc.size(), 1);
        check("zero_done_cyc", qat(done_cyc, 0) - s0, 1);
        check("zero_rd_cnt", rd_cyc.size(), 0);
        check("zero_enin_cnt", enin_cyc.size(), 0);
        check("zero_eo_cnt", eo_cyc.size(), 0);

        // Abort at beat 2 of tile 1
        clear_logs();
        drive(1, 2, 'h040, 1, 0);
        repeat (10) drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 1);
        drive(0, 0, 0, 1, 0);
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_wvalid", int'(wvalid), 0);
        check("abort_en_out", int'(en_out), 0);
        check("abort_tile", int'(tile_idx), 1);
        drive(0, 0, 0, 1, 0);
        check("abort_eo_cnt", eo_cyc.size(), 6);
        check("abort_done_cnt", done_cyc.size(), 0);
        clear_logs();
        drive(1, 1, 'h200, 1, 0);
        drive(0, 0, 0, 1, 0);
        wait_idle(50);
        check("post_abort_wv", wv_cyc.size(), 4);
        check("post_abort_done", done_cyc.size(), 1);

        // Reset during LOAD, then start while busy
        clear_logs();
        drive(1, 2, 'h100, 1, 0);
        drive(0, 0, 0, 1, 0);
        @(posedge clk);
        #2;
        check("pre_rst_en_in", int'(en_in), 1);
        rst = 1'b1;
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_rd_en", int'(mem_rd_en), 0);
        check("rst_en_in", int'(en_in), 0);
        check("rst_en_out", int'(en_out), 0);
        check("rst_wvalid", int'(wvalid), 0);
        check("rst_rd_addr", int'(mem_rd_addr), 0);
        check("rst_beat", int'(beat_idx), 0);
        check("rst_tile", int'(tile_idx), 0);
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (3) drive(0, 0, 0, 1, 0);
        check("no_resume_busy", int'(busy), 0);
        check("no_resume_rd", rd_cyc.size(), 1);
        clear_logs();
        drive(1, 2, 'h020, 1, 0);
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 1, 0);
        drive(1, 5, 'h300, 1, 0);
        drive(0, 0, 0, 1, 0);
        wait_idle(100);
        check("busy_start_rd_cnt", rd_cyc.size(), 2);
        check("busy_start_rd0", qat(rd_addr, 0), 'h020);
        check("busy_start_rd1", qat(rd_addr, 1), 'h021);
        check("busy_start_wv", wv_cyc.size(), 8);
        check("busy_start_done", done_cyc.size(), 1);

        // Maximum tile count
        clear_logs();
        drive(1, 255, 'h005, 1, 0);
        drive(0, 0, 0, 1, 0);
        wait_idle(2000);
        check("max_rd_cnt", rd_cyc.size(), 255);
        check("max_rd_last", qat(rd_addr, 254), 'h103);
        check("max_wv_cnt", wv_cyc.size(), 1020);
        check("max_done_cnt", done_cyc.size(), 1);
        check("max_tile_end", int'(tile_idx), 254);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 150) == 0) begin
                @(posedge clk);
                #2 rst = 1'b1;
                @(posedge clk);
                #2 rst = 1'b0;
            end
            drive($urandom_range(0, 5) == 0, $urandom_range(0, 4), $urandom_range(0, AMASK),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 30) == 0);
        end
        drive(0, 0, 0, 1, 0);
        wait_idle(200);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
